ssenc: RTL

SSENC -- requirements
Module: ssenc

---
 rtl/ssenc_if.sv | 12 +
 rtl/ssenc.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ssenc_if.sv
// Seven-segment decoder handshake bundle: pattern and ready in, decoded result out.
interface ssenc_if;
  logic [6:0] seg;
  logic       ready;
  logic       valid;
  logic [3:0] hex;
  logic       err;
  logic       blank;

  modport master (output seg, ready, input valid, hex, err, blank);
  modport slave  (input seg, ready, output valid, hex, err, blank);
endinterface

// File: rtl/ssenc.sv
// Debounced seven-segment decoder: reports a pattern once it has held STABLE_CYCLES samples, then holds it until ready.
// Define SSENC_BLANK_EN to report an all-zero pattern as blank instead of err.
module ssenc #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic  hz100,
  input  logic  reset,
  ssenc_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETTLE   = 2'd1;
  localparam logic [1:0] OFFER    = 2'd2;
  localparam logic [1:0] WAIT_CHG = 2'd3;

  localparam logic [7:0] CNT_TGT = 8'(STABLE_CYCLES - 1);

  logic [1:0] state;
  logic [6:0] seg_q;
  logic [6:0] pat;
  logic [6:0] last_pat;
  logic [7:0] cnt;
  logic [3:0] hex_r;
  logic       err_r;
  logic       change;
  logic [4:0] dec;
  logic       nxt_blank;
  logic       nxt_err;
  logic [3:0] nxt_hex;

  // Returns {legal, digit}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = {1'b1, 4'h0};
      7'b0000110: decode = {1'b1, 4'h1};
      7'b1011011: decode = {1'b1, 4'h2};
      7'b1001111: decode = {1'b1, 4'h3};
      7'b1100110: decode = {1'b1, 4'h4};
      7'b1101101: decode = {1'b1, 4'h5};
      7'b1111101: decode = {1'b1, 4'h6};
      7'b0000111: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1100111: decode = {1'b1, 4'h9};
      7'b1110111: decode = {1'b1, 4'hA};
      7'b1111100: decode = {1'b1, 4'hB};
      7'b0111001: decode = {1'b1, 4'hC};
      7'b1011110: decode = {1'b1, 4'hD};
      7'b1111001: decode = {1'b1, 4'hE};
      7'b1110001: decode = {1'b1, 4'hF};
      default:    decode = {1'b0, 4'h0};
    endcase
  endfunction

  always_comb begin
    change  = (bus.seg != seg_q);
    dec     = decode(seg_q);
`ifdef SSENC_BLANK_EN
    nxt_blank = (seg_q == 7'd0);
`else
    nxt_blank = 1'b0;
`endif
    nxt_err = !dec[4] && !nxt_blank;
    nxt_hex = dec[4] ? dec[3:0] : 4'h0;
  end

`ifdef SSENC_BLANK_EN
  logic blank_r;
  always_ff @(posedge hz100) begin
    if (reset)
      blank_r <= 1'b0;
    else if (state == SETTLE && !change && cnt == CNT_TGT)
      blank_r <= nxt_blank;
  end
  assign bus.blank = blank_r;
`else
  assign bus.blank = 1'b0;
`endif

  always_ff @(posedge hz100) begin
    if (reset) begin
      state    <= IDLE;
      seg_q    <= 7'd0;
      pat      <= 7'd0;
      last_pat <= 7'd0;
      cnt      <= 8'd0;
      hex_r    <= 4'h0;
      err_r    <= 1'b0;
    end else begin
      seg_q <= bus.seg;
      if (change)
        cnt <= 8'd0;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;

      case (state)
        IDLE: state <= SETTLE;
        SETTLE: begin
          if (!change && cnt == CNT_TGT) begin
            pat   <= seg_q;
            hex_r <= nxt_hex;
            err_r <= nxt_err;
            state <= OFFER;
          end
        end
        OFFER: begin
          if (bus.ready) begin
            last_pat <= pat;
            state    <= WAIT_CHG;
          end
        end
        default: begin
          // A pattern that changed during OFFER is caught here and re-settled from scratch.
          if (seg_q != last_pat) begin
            state <= SETTLE;
            cnt   <= 8'd0;
          end
        end
      endcase
    end
  end

  assign bus.valid = (state == OFFER);
  assign bus.hex   = hex_r;
  assign bus.err   = err_r;

endmodule
